// File: rtl/header_rx_framer.sv
// header_rx_framer: assembles NUM_BYTES UART bytes into one block-header word,
// publishes it with a valid/ack handshake, and drops partial frames after an
// inter-byte timeout. The header register is separate from the shift buffer so a
// new frame can stream in while the core still holds the previous header.
module header_rx_framer #(
    parameter int NUM_BYTES      = 80,
    parameter int DATA_WIDTH     = 640,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rdy_clr,
    output logic [DATA_WIDTH-1:0] header,
    output logic                  header_valid,
    input  logic                  header_ack,
    output logic [6:0]            byte_count,
    output logic                  timeout_err,
    output logic                  overrun_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0]    LAST_COUNT = 7'(NUM_BYTES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CLRW = 2'd2
    } state_t;

    state_t                state_r;
    // The top byte of a full frame is never held here: on completion the header
    // is taken from the shifted value that already includes the final byte.
    logic [DATA_WIDTH-9:0] buffer_r;
    logic [TW-1:0]         timer_r;

    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  capture_s;
    logic                  last_byte_s;
    logic                  timer_on_s;
    logic                  expire_s;

    // Decode capture, completion and timer-expiry conditions for this cycle.
    always_comb begin
        shifted_s   = {buffer_r, rx_data};
        capture_s   = 1'b0;
        last_byte_s = 1'b0;
        timer_on_s  = 1'b0;
        expire_s    = 1'b0;
        if ((state_r == IDLE) || (state_r == RECV)) begin
            capture_s = rx_rdy;
        end else begin
            capture_s = 1'b0;
        end
        if (byte_count == LAST_COUNT) begin
            last_byte_s = 1'b1;
        end else begin
            last_byte_s = 1'b0;
        end
        if (((state_r == RECV) || (state_r == CLRW)) && (byte_count != 7'd0)) begin
            timer_on_s = 1'b1;
        end else begin
            timer_on_s = 1'b0;
        end
        // A capture in the same cycle always beats the timeout.
        if (timer_on_s && (timer_r == TIMER_LAST) && !capture_s) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Framer state machine with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            buffer_r     <= '0;
            timer_r      <= '0;
            rdy_clr      <= 1'b0;
            header       <= '0;
            header_valid <= 1'b0;
            byte_count   <= 7'd0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            rdy_clr     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            // Ack clears valid; a completion below in the same cycle re-asserts it.
            if (header_ack && header_valid) begin
                header_valid <= 1'b0;
            end else begin
                header_valid <= header_valid;
            end
            case (state_r)
                IDLE, RECV: begin
                    if (capture_s) begin
                        buffer_r <= shifted_s[DATA_WIDTH-9:0];
                        rdy_clr  <= 1'b1;
                        timer_r  <= '0;
                        state_r  <= CLRW;
                        if (last_byte_s) begin
                            header       <= shifted_s;
                            header_valid <= 1'b1;
                            byte_count   <= 7'd0;
                            if (header_valid && !header_ack) begin
                                overrun_err <= 1'b1;
                            end else begin
                                overrun_err <= 1'b0;
                            end
                        end else begin
                            byte_count <= byte_count + 7'd1;
                        end
                    end else if (expire_s) begin
                        buffer_r    <= '0;
                        byte_count  <= 7'd0;
                        timer_r     <= '0;
                        timeout_err <= 1'b1;
                        state_r     <= IDLE;
                    end else if (timer_on_s) begin
                        timer_r <= timer_r + TW'(1);
                    end else begin
                        timer_r <= '0;
                    end
                end
                CLRW: begin
                    if (expire_s) begin
                        buffer_r    <= '0;
                        byte_count  <= 7'd0;
                        timer_r     <= '0;
                        timeout_err <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        if (timer_on_s) begin
                            timer_r <= timer_r + TW'(1);
                        end else begin
                            timer_r <= '0;
                        end
                        // rx_rdy stays high until the UART sees the strobe; wait it out.
                        if (!rx_rdy) begin
                            if (byte_count == 7'd0) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= RECV;
                            end
                        end else begin
                            state_r <= CLRW;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
